// File: rtl/calculadora_multiciclo.sv
// Multi-cycle RV32I-subset ALU calculator: IDLE -> DECODE -> EXEC -> WB over an
// internal register file with x0 hardwired to zero and a combinational read port.
module calculadora_multiciclo #(
    parameter int W      = 32,
    parameter int N_REGS = 32,
    localparam int RW    = $clog2(N_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          opera,
    input  logic [31:0]   instr,
    input  logic [RW-1:0] read,
    output logic [W-1:0]  data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   retired
);

    localparam int SH   = $clog2(W);
    localparam int IMMB = (W < 12) ? W : 12;
    localparam logic [5:0] NREG6 = 6'(N_REGS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    logic [1:0]   r_state;
    logic [31:0]  r_instr;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;
    logic [W-1:0] r_rf [N_REGS];
    logic         r_done;
    logic         r_err;
    logic [15:0]  r_retired;

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [4:0]   w_rd;
    logic [4:0]   w_rs1;
    logic [4:0]   w_rs2;
    logic         w_isImm;
    logic         w_isReg;
    logic         w_opLegal;
    logic         w_regsLegal;
    logic         w_legal;
    logic [W-1:0] w_imm;
    logic [W-1:0] w_alu;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_funct3 = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];
    assign w_funct7 = r_instr[31:25];
    assign w_isImm  = (w_opcode == 7'b0010011);
    assign w_isReg  = (w_opcode == 7'b0110011);

    always_comb begin
        w_opLegal = 1'b0;
        if (w_isImm) begin
            case (w_funct3)
                3'b000, 3'b111, 3'b110, 3'b100: w_opLegal = 1'b1;
                3'b001:                         w_opLegal = (w_funct7 == 7'b0000000);
                default:                        w_opLegal = 1'b0;
            endcase
        end else if (w_isReg) begin
            if (w_funct7 == 7'b0000000) begin
                case (w_funct3)
                    3'b000, 3'b111, 3'b110, 3'b100, 3'b001: w_opLegal = 1'b1;
                    default:                                 w_opLegal = 1'b0;
                endcase
            end else if (w_funct7 == 7'b0100000) begin
                w_opLegal = (w_funct3 == 3'b000);
            end
        end
    end

    // rs2 only matters for the register-register form; the immediate form reuses those bits.
    assign w_regsLegal = ({1'b0, w_rd} < NREG6) && ({1'b0, w_rs1} < NREG6) &&
                         (!w_isReg || ({1'b0, w_rs2} < NREG6));
    assign w_legal     = w_opLegal && w_regsLegal;

    always_comb begin
        w_imm = {W{r_instr[31]}};
        for (int i = 0; i < IMMB; i++) begin
            w_imm[i] = r_instr[20 + i];
        end
    end

    always_comb begin
        w_alu = '0;
        case (w_funct3)
            3'b000:  w_alu = (w_isReg && w_funct7[5]) ? (r_a - r_b) : (r_a + r_b);
            3'b111:  w_alu = r_a & r_b;
            3'b110:  w_alu = r_a | r_b;
            3'b100:  w_alu = r_a ^ r_b;
            3'b001:  w_alu = r_a << r_b[SH-1:0];
            default: w_alu = '0;
        endcase
    end

    // Entry 0 is cleared by reset and never written afterwards, which makes x0 read as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
            for (int i = 0; i < N_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (opera) begin
                        r_instr <= instr;
                        r_err   <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_a     <= r_rf[w_rs1[RW-1:0]];
                        r_b     <= w_isReg ? r_rf[w_rs2[RW-1:0]] : w_imm;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= w_alu;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    if (w_rd != 5'd0) begin
                        r_rf[w_rd[RW-1:0]] <= r_result;
                    end
                    r_retired <= r_retired + 16'd1;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data    = r_rf[read];
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign err     = r_err;
    assign retired = r_retired;

endmodule

// File: tb/tb_calculadora_multiciclo.sv
// Scoreboard bench: stimulus pushes expected results from an arithmetic reference
// model; an independent monitor pops and checks them whenever done (or a snapshot request) appears.
`timescale 1ns/1ns
module tb_calculadora_multiciclo;

    localparam int W      = 16;
    localparam int N_REGS = 8;
    localparam int RW     = $clog2(N_REGS);

    typedef struct packed {
        logic                       isSnap;
        logic                       err;
        logic [15:0]                retired;
        logic [31:0]                doneCycle;
        logic [7:0]                 busyLen;
        logic [N_REGS-1:0][W-1:0]   rf;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          opera;
    logic [31:0]   instr;
    logic [RW-1:0] readIdx;
    logic [W-1:0]  data;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   retired;

    int            checks;
    int            failures;
    logic [31:0]   cycleCount;
    logic          snapReq;
    int            busyRun;
    exp_t          expQ[$];

    logic [W-1:0]  mRf [N_REGS];
    logic [15:0]   mRetired;
    logic          mErr;
    logic [2:0]    f3Tab [5];

    calculadora_multiciclo #(.W(W), .N_REGS(N_REGS)) dut (
        .clock   (clock),
        .reset   (reset),
        .opera   (opera),
        .instr   (instr),
        .read    (readIdx),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .retired (retired)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial cycleCount = '0;
    always @(posedge clock) cycleCount <= cycleCount + 32'd1;

    task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    function automatic exp_t snapshot(input logic isSnap, input logic [7:0] busyLen, input logic [31:0] doneCycle);
        exp_t e;
        e.isSnap    = isSnap;
        e.err       = mErr;
        e.retired   = mRetired;
        e.busyLen   = busyLen;
        e.doneCycle = doneCycle;
        for (int i = 0; i < N_REGS; i++) e.rf[i] = mRf[i];
        return e;
    endfunction

    // Reference model: decode fields, then plain arithmetic modulo 2^W.
    function automatic logic modelExec(input logic [31:0] w);
        int          op, f3, f7, rd, rs1, rs2, immS;
        logic        legal, isR;
        logic [W-1:0] a, b, res;
        op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
        rd = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
        immS = $signed(w[31:20]);
        legal = 1'b0; isR = 1'b0;
        if (op == 'h13) legal = (f3 == 0 || f3 == 7 || f3 == 6 || f3 == 4) || (f3 == 1 && f7 == 0);
        else if (op == 'h33) begin
            isR = 1'b1;
            legal = (f7 == 0 && (f3 == 0 || f3 == 7 || f3 == 6 || f3 == 4 || f3 == 1)) || (f7 == 'h20 && f3 == 0);
        end
        if (rd >= N_REGS || rs1 >= N_REGS || (isR && rs2 >= N_REGS)) legal = 1'b0;
        if (legal) begin
            a = mRf[rs1];
            b = isR ? mRf[rs2] : W'(immS);
            case (f3)
                0:       res = (isR && f7 == 'h20) ? a - b : a + b;
                7:       res = a & b;
                6:       res = a | b;
                4:       res = a ^ b;
                default: res = a << (int'(b) % W);
            endcase
            if (rd != 0) mRf[rd] = res;
            mRetired = mRetired + 16'd1;
            mErr = 1'b0;
        end else begin
            mErr = 1'b1;
        end
        return legal;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N_REGS; i++) mRf[i] = '0;
        mRetired = '0;
        mErr = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] word, input int hold);
        logic legal;
        logic [31:0] base;
        base  = cycleCount;
        legal = modelExec(word);
        expQ.push_back(snapshot(1'b0, legal ? 8'd3 : 8'd1, legal ? base + 32'd4 : base + 32'd2));
        instr = word;
        opera = 1'b1;
        repeat (legal ? hold : 1) @(negedge clock);
        opera = 1'b0;
    endtask

    task automatic pushSnap();
        expQ.push_back(snapshot(1'b1, 8'd0, 32'd0));
        snapReq = 1'b1;
        @(negedge clock);
        snapReq = 1'b0;
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 40 && expQ.size() != 0; k++) @(negedge clock);
        compareVal("drain_timeout", 64'(expQ.size()), 64'd0);
        expQ.delete();
    endtask

    task automatic checkOutput(input exp_t e);
        compareVal("kind_snapshot", {63'd0, snapReq}, {63'd0, e.isSnap});
        compareVal("err", {63'd0, err}, {63'd0, e.err});
        compareVal("retired", 64'(retired), 64'(e.retired));
        if (e.isSnap) begin
            compareVal("snap_busy", {63'd0, busy}, 64'd0);
            compareVal("snap_done", {63'd0, done}, 64'd0);
        end else begin
            compareVal("done_cycle", 64'(cycleCount), 64'(e.doneCycle));
            compareVal("busy_cycles", 64'(busyRun), 64'(e.busyLen));
        end
        for (int i = 0; i < N_REGS; i++) begin
            readIdx = RW'(i);
            #1;
            compareVal($sformatf("rf_x%0d", i), 64'(data), 64'(e.rf[i]));
        end
    endtask

    initial begin
        exp_t e;
        busyRun = 0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                busyRun = 0;
            end else if (done || snapReq) begin
                if (expQ.size() == 0) begin
                    compareVal("unexpected_output", {63'd0, done}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput(e);
                end
                busyRun = 0;
            end else if (busy) begin
                busyRun++;
            end
        end
    end

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        int          t;
        t   = int'($urandom_range(0, 15));
        rd  = 5'($urandom_range(0, 8));
        rs1 = 5'($urandom_range(0, 8));
        rs2 = 5'($urandom_range(0, 8));
        f3  = f3Tab[$urandom_range(0, 4)];
        if (t == 0) begin
            w = $urandom();
        end else if (t < 8) begin
            imm = 12'($urandom_range(0, 4095));
            if (f3 == 3'd1 && t != 7) imm[11:5] = 7'd0;
            w = {imm, rs1, f3, rd, 7'b0010011};
        end else begin
            f7 = (t == 15) ? 7'h01 : ((t >= 12) ? 7'h20 : 7'h00);
            w = {f7, rs2, rs1, f3, rd, 7'b0110011};
        end
        return w;
    endfunction

    initial begin
        logic [31:0] base;
        logic        l1, l2;
        checks = 0; failures = 0;
        f3Tab = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd1};
        reset = 1'b1; opera = 1'b0; instr = '0; readIdx = '0; snapReq = 1'b0;
        modelReset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        pushSnap();

        applyStimulus(32'h00500093, 1); waitIdle();
        applyStimulus(32'h00100013, 1); waitIdle();
        applyStimulus(32'hFFF00113, 1); waitIdle();
        applyStimulus(32'h402081B3, 1); waitIdle();
        applyStimulus(32'h7FF00213, 1); waitIdle();
        applyStimulus(32'h00309293, 1); waitIdle();
        applyStimulus(32'h00209333, 1); waitIdle();
        applyStimulus(32'hFFFFFFFF, 1); waitIdle();
        applyStimulus(32'h00100493, 1); waitIdle();
        applyStimulus(32'h00208393, 1); waitIdle();

        // A second request while busy must be dropped, not queued.
        applyStimulus(32'h05500313, 1);
        @(negedge clock);
        instr = 32'h0AA00393;
        opera = 1'b1;
        @(negedge clock);
        opera = 1'b0;
        waitIdle();

        // Holding opera high gives back-to-back accepts four edges apart.
        base = cycleCount;
        l1 = modelExec(32'h00108093);
        expQ.push_back(snapshot(1'b0, 8'd3, base + 32'd4));
        l2 = modelExec(32'h00A00213);
        expQ.push_back(snapshot(1'b0, 8'd3, base + 32'd8));
        compareVal("b2b_model_legal", {62'd0, l1, l2}, 64'd3);
        instr = 32'h00108093;
        opera = 1'b1;
        repeat (2) @(negedge clock);
        instr = 32'h00A00213;
        repeat (3) @(negedge clock);
        opera = 1'b0;
        waitIdle();

        // Reset while the instruction is in EXEC: nothing is written and everything clears.
        instr = 32'h07B00093;
        opera = 1'b1;
        @(negedge clock);
        opera = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        pushSnap();

        for (int n = 0; n < 150; n++) begin
            applyStimulus(randInstr(), int'($urandom_range(1, 4)));
            waitIdle();
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        compareVal("final_queue_empty", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calculadora_multiciclo.md
Name: calculadora_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-step calculator.
- Accepts one RV32I-style ALU instruction per `opera` request on the `instr` port and executes it through a 4-state FSM against an internal register file.
- Exposes an asynchronous register read port, a busy/done handshake, an illegal-instruction flag and a retired-instruction counter.
- Sits between the lab test bench / a future fetch unit and the register file.

Parameters:
- W, 32, datapath and register width; power of two, 8..64.
- N_REGS, 32, number of registers; power of two, 2..32; x0 hardwired to zero.
- RW, $clog2(N_REGS), read-port index width (derived, not overridden).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opera  in  1  request to execute `instr`; sampled only in IDLE.
- instr  in  32  instruction word; sampled on the same edge as `opera`.
- read  in  RW  register index for the `data` port.
- data  out  W  RF[read], combinational read; x0 reads 0.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse after writeback (or after an illegal-instruction abort).
- err  out  1  last accepted instruction was illegal; held until the next accept.
- retired  out  16  count of legally completed instructions; wraps 0xFFFF to 0.

Behaviour:
- Reset, on a clock edge with reset=1:
  - FSM goes to IDLE; all RF entries, busy, done, err and retired go to 0.
  - Any instruction in flight is aborted with no RF write.
  - Reset has priority over opera.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: on an edge with opera=1, latch `instr`, clear err, go to DECODE. With opera=0, stay in IDLE.
  - DECODE: check legality and latch operands A=RF[rs1] and B (RF[rs2] or sign-extended imm).
    - Illegal: set err=1, pulse done, return to IDLE; no write, retired unchanged.
    - Legal: go to EXEC.
  - EXEC: result register <= ALU(A, B); go to WB.
  - WB: RF[rd] <= result unless rd=0; retired += 1; done <= 1 for the next cycle; go to IDLE.
- Latency, with the accept edge counted as E0:
  - RF write occurs at E3; `data` shows the new value after E3.
  - busy is high from after E0 until after E3.
  - done is high for the cycle following E3.
  - Illegal instructions: done is high for the cycle following E1.
- opera while busy is ignored; no queueing. If opera is held high continuously, the next accept is at E4 (a 4-cycle throughput).
- Legal encodings:
  - opcode 0010011:
    - funct3 000 addi, 111 andi, 110 ori, 100 xori.
    - funct3 001 slli, only with funct7=0000000.
  - opcode 0110011:
    - funct7 0000000: funct3 000 add, 111 and, 110 or, 100 xor, 001 sll.
    - funct7 0100000: funct3 000 sub.
  - Everything else is illegal.
  - Any of rd, rs1 or rs2 (when used) >= N_REGS is also illegal.
- Arithmetic rules:
  - All arithmetic is modulo 2^W; overflow is silently discarded.
  - imm[11:0] is sign-extended to W.
  - Shift amount is B[$clog2(W)-1:0]; upper bits are ignored.
- The x0 read always returns 0 on both the data port and the operand path, even if a write targets rd=0.
- `data` follows `read` combinationally, with no clock involvement.

Test Plan:
- Reset, then read x0..x(N_REGS-1) -> all 0; busy=0, done=0, err=0, retired=0.
- addi x1,x0,5 (0x00500093) with a 1-cycle opera pulse -> busy high for 3 cycles, done pulse, RF[1]=5, retired=1. Then addi x0,x0,1 -> RF[0] reads 0, retired=2.
- addi x2,x0,-1 then sub x3,x1,x2 (0x402081B3) -> RF[2]=all ones; RF[3]=6. With W=8, also check addi x4,x0,0x7FF gives RF[4]=0xFF.
- slli x5,x1,3 (0x00309293) -> RF[5]=40. Then sll with rs2=RF[2] (all ones, amount masked to W-1) -> RF[dest]=RF[1]<<(W-1).
- Illegal word 0xFFFFFFFF, and, with N_REGS=8, addi x9,x0,1 -> err=1, done pulse after E1, no RF change, retired unchanged. The next legal instruction clears err.
- Mid-op events:
  - Pulse opera again during busy -> ignored; only one write.
  - Assert reset in EXEC -> no write, all registers 0, FSM in IDLE next cycle.
